// File: rtl/steer_quad_gen_if.sv
// rtl/steer_quad_gen_if.sv - steering button inputs and quadrature/status outputs
interface steer_quad_gen_if;
  logic       left;
  logic       right;
  logic [1:0] steer;
  logic       moving;
  logic       dir;
  logic [7:0] position;

  // master drives the buttons; slave is the quadrature generator
  modport master (
    output left, right,
    input  steer, moving, dir, position
  );

  modport slave (
    input  left, right,
    output steer, moving, dir, position
  );
endinterface

// File: rtl/steer_quad_gen.sv
// rtl/steer_quad_gen.sv - button-to-quadrature steering wheel emulator with acceleration ramp
module steer_quad_gen #(
  parameter int WIDTH      = 16,
  parameter int DIV_MAX    = 22500,
  parameter int DIV_MIN    = 5625,
  parameter int ACCEL_STEP = 1875
) (
  input  logic            CLK,
  input  logic            reset,
  steer_quad_gen_if.slave sq
);

  localparam logic [WIDTH-1:0] PER_MAX    = WIDTH'(DIV_MAX);
  localparam logic [WIDTH-1:0] PER_MAX_M1 = WIDTH'(DIV_MAX - 1);
  localparam logic [WIDTH-1:0] PER_MIN    = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] PER_STEP   = WIDTH'(ACCEL_STEP);
  localparam logic [WIDTH:0]   SAT_LIM    = (WIDTH+1)'(DIV_MIN) + (WIDTH+1)'(ACCEL_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             run_dir, run_dir_nxt;
  logic [WIDTH-1:0] period, period_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [1:0]       steer_q, steer_nxt;
  logic             dir_q, dir_nxt;
  logic [7:0]       pos_q, pos_nxt;
  logic             moving_q;
  logic             req_r, req_l;

  assign req_r = sq.right & ~sq.left;
  assign req_l = sq.left & ~sq.right;

  always_comb begin
    state_nxt   = state;
    run_dir_nxt = run_dir;
    period_nxt  = period;
    cnt_nxt     = cnt;
    phase_nxt   = phase;
    dir_nxt     = dir_q;
    pos_nxt     = pos_q;

    case (state)
      IDLE: begin
        if (req_r | req_l) begin
          state_nxt   = RUN;
          run_dir_nxt = req_r;
          period_nxt  = PER_MAX;
          cnt_nxt     = PER_MAX_M1;
        end
      end
      RUN: begin
        if (!(req_r | req_l)) begin
          state_nxt  = IDLE;
          period_nxt = PER_MAX;
        end else if (req_r != run_dir) begin
          // direction reversal restarts the ramp without stepping
          run_dir_nxt = req_r;
          period_nxt  = PER_MAX;
          cnt_nxt     = PER_MAX_M1;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - WIDTH'(1);
        end else begin
          phase_nxt  = run_dir ? phase + 2'd1 : phase - 2'd1;
          dir_nxt    = run_dir;
          pos_nxt    = run_dir ? pos_q + 8'd1 : pos_q - 8'd1;
          period_nxt = ({1'b0, period} >= SAT_LIM) ? period - PER_STEP : PER_MIN;
          cnt_nxt    = period_nxt - WIDTH'(1);
        end
      end
    endcase

    // phase index to Gray-coded {A,B}
    case (phase_nxt)
      2'd0:    steer_nxt = 2'b00;
      2'd1:    steer_nxt = 2'b01;
      2'd2:    steer_nxt = 2'b11;
      default: steer_nxt = 2'b10;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      run_dir  <= 1'b1;
      period   <= PER_MAX;
      cnt      <= '0;
      phase    <= 2'd0;
      steer_q  <= 2'b00;
      dir_q    <= 1'b1;
      pos_q    <= 8'd0;
      moving_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_dir  <= run_dir_nxt;
      period   <= period_nxt;
      cnt      <= cnt_nxt;
      phase    <= phase_nxt;
      steer_q  <= steer_nxt;
      dir_q    <= dir_nxt;
      pos_q    <= pos_nxt;
      moving_q <= (state_nxt == RUN);
    end
  end

  assign sq.steer    = steer_q;
  assign sq.moving   = moving_q;
  assign sq.dir      = dir_q;
  assign sq.position = pos_q;

endmodule

// File: tb/tb_steer_quad_gen.sv
// tb/tb_steer_quad_gen.sv - self-checking bench for steer_quad_gen
module tb_steer_quad_gen;
  localparam int DMAX = 8;
  localparam int DMIN = 2;
  localparam int ACC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  steer_quad_gen_if sq();

  always #5 clk = ~clk;

  steer_quad_gen #(
    .WIDTH(16), .DIV_MAX(DMAX), .DIV_MIN(DMIN), .ACCEL_STEP(ACC)
  ) dut (
    .CLK(clk),
    .reset(reset),
    .sq(sq)
  );

  // Reference: a step is due when the time since the last step (or run start)
  // equals the k-th period of the ramp; the wheel angle is the step count mod 4.
  int   cyc = 0;
  bit   m_run = 1'b0;
  bit   m_rdir = 1'b1;
  int   m_last = 0;
  int   m_k = 0;
  int   m_pos = 0;
  bit   m_dir = 1'b1;
  logic [1:0] gmap [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int per_of(int k);
    int p;
    p = DMAX - k * ACC;
    return (p < DMIN) ? DMIN : p;
  endfunction

  always @(posedge clk) begin
    bit rr, rl;
    cyc++;
    rr = sq.right & ~sq.left;
    rl = sq.left & ~sq.right;
    if (reset) begin
      m_run = 1'b0;
      m_pos = 0;
      m_dir = 1'b1;
    end else if (!m_run) begin
      if (rr | rl) begin
        m_run = 1'b1; m_rdir = rr; m_last = cyc; m_k = 0;
      end
    end else if (!(rr | rl)) begin
      m_run = 1'b0;
    end else if (rr != m_rdir) begin
      m_rdir = rr; m_last = cyc; m_k = 0;
    end else if (cyc - m_last == per_of(m_k)) begin
      m_pos  = m_pos + (m_rdir ? 1 : -1);
      m_dir  = m_rdir;
      m_last = cyc;
      m_k++;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("steer",    32'(sq.steer),    32'(gmap[m_pos & 3]));
    chk("moving",   32'(sq.moving),   32'(m_run));
    chk("dir",      32'(sq.dir),      32'(m_dir));
    chk("position", 32'(sq.position), 32'(m_pos[7:0]));
  end

  task automatic set_in(bit l, bit r);
    @(negedge clk);
    sq.left  = l;
    sq.right = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sq.left = 1'b0;
    sq.right = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic at_edge(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  int e0;

  initial begin
    sq.left = 1'b0;
    sq.right = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    at_edge(cyc + 50);
    chk("idle_steer", 32'(sq.steer), 32'h0);
    chk("idle_moving", 32'(sq.moving), 32'h0);
    chk("idle_pos", 32'(sq.position), 32'h0);
    chk("idle_dir", 32'(sq.dir), 32'h1);

    // right held: steps at +8,14,18,20,22,24
    do_reset(); set_in(0, 1); e0 = cyc + 1;
    at_edge(e0);      chk("r_enter_mv", 32'(sq.moving), 32'h1);
    at_edge(e0 + 7);  chk("r_e7", 32'(sq.steer), 32'h0);
    at_edge(e0 + 8);  chk("r_e8", 32'(sq.steer), 32'h1);
    at_edge(e0 + 13); chk("r_e13", 32'(sq.steer), 32'h1);
    at_edge(e0 + 14); chk("r_e14", 32'(sq.steer), 32'h3);
    at_edge(e0 + 18); chk("r_e18", 32'(sq.steer), 32'h2);
    at_edge(e0 + 20); chk("r_e20", 32'(sq.steer), 32'h0);
    at_edge(e0 + 22); chk("r_e22", 32'(sq.steer), 32'h1);
    at_edge(e0 + 24); chk("r_e24", 32'(sq.steer), 32'h3);
    chk("r_pos6", 32'(sq.position), 32'h6);
    set_in(0, 0); e0 = cyc + 1;
    at_edge(e0);
    chk("rel_moving", 32'(sq.moving), 32'h0);
    chk("rel_steer", 32'(sq.steer), 32'h3);

    // left held 30 cycles
    do_reset(); set_in(1, 0); e0 = cyc + 1;
    at_edge(e0 + 8);  chk("l_e8", 32'(sq.steer), 32'h2);
    at_edge(e0 + 14); chk("l_e14", 32'(sq.steer), 32'h3);
    at_edge(e0 + 18); chk("l_e18", 32'(sq.steer), 32'h1);
    at_edge(e0 + 20); chk("l_e20", 32'(sq.steer), 32'h0);
    chk("l_pos", 32'(sq.position), 32'hFC);
    chk("l_dir", 32'(sq.dir), 32'h0);
    at_edge(e0 + 30); set_in(0, 0);

    // reversal at E10 restarts the ramp
    do_reset(); set_in(0, 1); e0 = cyc + 1;
    at_edge(e0 + 9); set_in(1, 0);
    at_edge(e0 + 10);
    chk("rev_e10_steer", 32'(sq.steer), 32'h1);
    chk("rev_e10_dir", 32'(sq.dir), 32'h1);
    at_edge(e0 + 17); chk("rev_e17", 32'(sq.steer), 32'h1);
    at_edge(e0 + 18);
    chk("rev_e18_steer", 32'(sq.steer), 32'h0);
    chk("rev_e18_dir", 32'(sq.dir), 32'h0);
    chk("rev_e18_pos", 32'(sq.position), 32'h0);
    set_in(0, 0);

    // both pressed while running, then release left
    do_reset(); set_in(0, 1); e0 = cyc + 1;
    at_edge(e0 + 9); set_in(1, 1);
    at_edge(e0 + 10);
    chk("both_moving", 32'(sq.moving), 32'h0);
    chk("both_steer", 32'(sq.steer), 32'h1);
    at_edge(e0 + 14); set_in(0, 1);
    at_edge(e0 + 15); chk("both_rerun", 32'(sq.moving), 32'h1);
    at_edge(e0 + 22); chk("both_e22", 32'(sq.steer), 32'h1);
    at_edge(e0 + 23); chk("both_e23", 32'(sq.steer), 32'h3);
    set_in(0, 0);

    // reset on the step edge
    do_reset(); set_in(0, 1); e0 = cyc + 1;
    at_edge(e0 + 7);
    @(negedge clk); reset = 1'b1;
    at_edge(e0 + 8);
    chk("rst_steer", 32'(sq.steer), 32'h0);
    chk("rst_pos", 32'(sq.position), 32'h0);
    chk("rst_moving", 32'(sq.moving), 32'h0);

    // 128 right steps wrap the position
    do_reset(); set_in(0, 1); e0 = cyc + 1;
    at_edge(e0 + 266); chk("wrap_127", 32'(sq.position), 32'h7F);
    at_edge(e0 + 268); chk("wrap_m128", 32'(sq.position), 32'h80);
    set_in(0, 0);
    at_edge(cyc + 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/steer_quad_gen.md
Name: steer_quad_gen

Overview:
- Converts digital left/right steering buttons into a 2-bit quadrature pair for the Sprint 1 core's SteerA_I/SteerB_I inputs.
- Sits directly upstream of the game core, in the 6 MHz core-clock domain.
- Emulates a spinning steering wheel with an acceleration ramp: step rate starts slow and speeds up while the button is held.
- Also provides a wrapping position counter and status flags for OSD/debug use.

Parameters:
- WIDTH, 16, bit width of the period and divider counters.
- DIV_MAX, 22500, initial clock cycles per quadrature step at the start of a press (must be ≥ DIV_MIN).
- DIV_MIN, 5625, fastest clock cycles per step after the ramp completes (must be ≥ 1).
- ACCEL_STEP, 1875, amount the period decreases after each emitted step.

Ports:
- CLK  in  1  core clock; every register is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- left  in  1  steer-left request, active high, synchronous to CLK.
- right  in  1  steer-right request, active high, synchronous to CLK.
- steer  out  2  quadrature output {A,B}; bit 1 drives SteerA_I, bit 0 drives SteerB_I.
- moving  out  1  high while in the RUN state.
- dir  out  1  direction of the last step taken (1 = right, 0 = left).
- position  out  8  signed step count; +1 per right step, −1 per left step, wraps modulo 256.

Behaviour:
- Reset takes effect at the reset edge. Resulting values:
  - steer = 2'b00, phase index = 0
  - state = IDLE, moving = 0, dir = 1, position = 0
  - period = DIV_MAX, cnt = 0
- Reset asserted mid-run aborts the run immediately; no step is emitted on the reset edge.
- Request decode each edge: req_r = right & ~left, req_l = left & ~right. Both pressed or neither pressed counts as no request.
- Phase sequence, right direction: 00 → 01 → 11 → 10 → 00. The left direction walks the same sequence in reverse.
  - Only one bit of steer changes per step (Gray code).
  - steer is registered and is never glitch-driven.
- IDLE state:
  - On an edge with req_r or req_l: go to RUN, latch run_dir, period ← DIV_MAX, cnt ← DIV_MAX−1.
  - No step is emitted on that entry edge.
- RUN state, evaluated per edge in this priority order:
  1. No request: go to IDLE, period ← DIV_MAX. The phase holds its value (the wheel stops where it is) and no step is emitted.
  2. Request in the opposite direction to run_dir: stay in RUN, run_dir ← new direction, period ← DIV_MAX, cnt ← DIV_MAX−1, no step emitted. This restarts the ramp.
  3. Same direction and cnt ≠ 0: cnt ← cnt−1.
  4. Same direction and cnt == 0: emit one step.
     - Advance the phase by one in run_dir, update dir, position ± 1.
     - period ← (period ≥ DIV_MIN+ACCEL_STEP) ? period−ACCEL_STEP : DIV_MIN.
     - cnt ← new period − 1.
- Timing consequence: if a request is first sampled at edge E0, steps fall at E0+DIV_MAX, then +(DIV_MAX−ACCEL_STEP), and so on, saturating at DIV_MIN.
- The period never drops below DIV_MIN and never exceeds DIV_MAX.
- The saturation comparison is done at WIDTH+1 bits so it cannot overflow.
- moving = (state == RUN), registered.
- dir changes only when a step is actually emitted.
- position wraps: 127+1 → −128, and −128−1 → 127.

Test Plan:
- Setup for all scenarios: DIV_MAX=8, DIV_MIN=2, ACCEL_STEP=2.
- Reset release, no input for 50 cycles → steer=00, moving=0, position=0, dir=1.
- right held from edge E0 → steps at E0+8, 14, 18, 20, 22, 24; steer goes 01, 11, 10, 00, 01, 11; position = 6.
- left held 30 cycles from reset → steer goes 10, 11, 01, 00, …; position goes negative; dir=0; step spacing 8, 6, 4, 2, 2…
- right held for 10 cycles, then switch to left at E10 → no step at E10; next step at E18 (ramp restarted); that step reverses the phase (back from 01 to 00).
- left and right both high while in RUN → IDLE on the next edge, moving=0, steer frozen. Releasing left then restarts a right run with a first step DIV_MAX cycles later.
- reset asserted at the edge where cnt==0 → no step, steer=00, position=0.
- Hold right for 128 steps → position wraps 127 → −128.
